// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel frame path: default geometry, collector
// state encoding and the raster addressing helper.
package pixel_pkg;

    localparam int DEF_PIX_W = 8;
    localparam int DEF_IMG_W = 256;
    localparam int DEF_IMG_H = 32;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } coll_state_t;

    function automatic int unsigned raster_addr(input int unsigned row,
                                                input int unsigned col,
                                                input int unsigned width);
        return row * width + col;
    endfunction

endpackage

// File: rtl/frame_ram_sp.sv
// Single-port frame buffer with synchronous read (one-cycle read latency),
// written so synthesis maps it onto a block RAM.
module frame_ram_sp #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [PIX_W-1:0]  wdata,
    output logic [PIX_W-1:0]  rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; clearing it would block RAM inference, and frame contents may survive rst_n.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/pixel_frame_collector.sv
// Collects the filtered pixel stream into an IMG_W x IMG_H frame buffer and
// drains it in raster order over a valid/ready output with a one-entry skid.
module pixel_frame_collector
    import pixel_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int PIX_W  = DEF_PIX_W,
    parameter int ADDR_W = 13
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [PIX_W-1:0]         in_pixel,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PIX_W-1:0]         out_pixel,
    output logic [$clog2(IMG_H)-1:0] out_row,
    output logic [$clog2(IMG_W)-1:0] out_col,
    output logic                     frame_done,
    output logic                     drain_done,
    output logic                     drop_err
);

    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

    coll_state_t        state;
    logic [ROW_W-1:0]   wr_row, rd_row, pend_row, skid_row;
    logic [COL_W-1:0]   wr_col, rd_col, pend_col, skid_col;
    logic               pend_valid, skid_valid, rd_issued_all;
    logic [PIX_W-1:0]   skid_pixel, ram_rdata;
    logic [ADDR_W-1:0]  wr_addr, rd_addr, ram_addr;
    logic               ram_we, wr_last, rd_last, out_last, xfer, issue;
    logic [1:0]         occ;

    always_comb begin
        in_ready = (state == FILL);
        ram_we   = in_ready && in_valid;
        wr_addr  = ADDR_W'(raster_addr(32'(wr_row), 32'(wr_col), unsigned'(IMG_W)));
        rd_addr  = ADDR_W'(raster_addr(32'(rd_row), 32'(rd_col), unsigned'(IMG_W)));
        ram_addr = in_ready ? wr_addr : rd_addr;
        wr_last  = (wr_row == ROW_LAST) && (wr_col == COL_LAST);
        rd_last  = (rd_row == ROW_LAST) && (rd_col == COL_LAST);
        out_last = (out_row == ROW_LAST) && (out_col == COL_LAST);
        xfer     = out_valid && out_ready;
        // A read lands one cycle after issue; only issue when output+skid will have room for it.
        occ      = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, pend_valid};
        issue    = (state == DRAIN) && !rd_issued_all &&
                   ((occ < 2'd2) || ((occ == 2'd2) && xfer));
    end

    frame_ram_sp #(
        .PIX_W (PIX_W),
        .ADDR_W(ADDR_W),
        .DEPTH (IMG_W * IMG_H)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(in_pixel),
        .rdata(ram_rdata)
    );

    // NOTE: every register here uses <= so all updates see the pre-edge values, whatever the statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            wr_row        <= '0;
            wr_col        <= '0;
            rd_row        <= '0;
            rd_col        <= '0;
            rd_issued_all <= 1'b0;
            pend_valid    <= 1'b0;
            pend_row      <= '0;
            pend_col      <= '0;
            skid_valid    <= 1'b0;
            skid_pixel    <= '0;
            skid_row      <= '0;
            skid_col      <= '0;
            out_valid     <= 1'b0;
            out_pixel     <= '0;
            out_row       <= '0;
            out_col       <= '0;
            frame_done    <= 1'b0;
            drain_done    <= 1'b0;
            drop_err      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            drain_done <= 1'b0;
            pend_valid <= issue;
            pend_row   <= rd_row;
            pend_col   <= rd_col;
            if (in_valid && !in_ready) begin
                drop_err <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= FILL;
                    end
                end

                FILL: begin
                    if (in_valid) begin
                        if (wr_last) begin
                            state      <= DRAIN;
                            frame_done <= 1'b1;
                            wr_row     <= '0;
                            wr_col     <= '0;
                        end else if (wr_col == COL_LAST) begin
                            wr_col <= '0;
                            wr_row <= wr_row + ROW_W'(1);
                        end else begin
                            wr_col <= wr_col + COL_W'(1);
                        end
                    end
                end

                DRAIN: begin
                    if (issue) begin
                        if (rd_last) begin
                            rd_row        <= '0;
                            rd_col        <= '0;
                            rd_issued_all <= 1'b1;
                        end else if (rd_col == COL_LAST) begin
                            rd_col <= '0;
                            rd_row <= rd_row + ROW_W'(1);
                        end else begin
                            rd_col <= rd_col + COL_W'(1);
                        end
                    end

                    // Skid holds the older beat, so it refills the output before fresh RAM data.
                    if (xfer || !out_valid) begin
                        if (skid_valid) begin
                            out_valid  <= 1'b1;
                            out_pixel  <= skid_pixel;
                            out_row    <= skid_row;
                            out_col    <= skid_col;
                            skid_valid <= pend_valid;
                            skid_pixel <= ram_rdata;
                            skid_row   <= pend_row;
                            skid_col   <= pend_col;
                        end else begin
                            out_valid <= pend_valid;
                            if (pend_valid) begin
                                out_pixel <= ram_rdata;
                                out_row   <= pend_row;
                                out_col   <= pend_col;
                            end
                        end
                    end else if (pend_valid) begin
                        skid_valid <= 1'b1;
                        skid_pixel <= ram_rdata;
                        skid_row   <= pend_row;
                        skid_col   <= pend_col;
                    end

                    if (xfer && out_last) begin
                        state         <= IDLE;
                        drain_done    <= 1'b1;
                        out_valid     <= 1'b0;
                        rd_issued_all <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_frame_collector.sv
// Bench for pixel_frame_collector: a cycle table on a 4x2 instance plus
// full-frame sequences (stalls, backpressure, protocol errors, mid-frame reset).
module tb_pixel_frame_collector;

    localparam int W    = 256;
    localparam int H    = 32;
    localparam int NPIX = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_pixel = '0;
    logic       in_ready, out_valid, frame_done, drain_done, drop_err;
    logic [7:0] out_pixel;
    logic [4:0] out_row;
    logic [7:0] out_col;

    logic       s_start = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
    logic [7:0] s_in_pixel = '0;
    logic       s_in_ready, s_out_valid, s_frame_done, s_drain_done, s_drop_err;
    logic [7:0] s_out_pixel;
    logic [0:0] s_out_row;
    logic [1:0] s_out_col;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pixel_frame_collector #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .ADDR_W(13)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_pixel(in_pixel),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_row(out_row), .out_col(out_col), .frame_done(frame_done), .drain_done(drain_done),
        .drop_err(drop_err)
    );

    pixel_frame_collector #(.IMG_W(4), .IMG_H(2), .PIX_W(8), .ADDR_W(3)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_in_valid), .in_pixel(s_in_pixel),
        .in_ready(s_in_ready), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_pixel(s_out_pixel),
        .out_row(s_out_row), .out_col(s_out_col), .frame_done(s_frame_done), .drain_done(s_drain_done),
        .drop_err(s_drop_err)
    );

    typedef struct {
        logic       st, iv;
        logic [7:0] ip;
        logic       ordy;
        logic       ird, ov;
        logic [7:0] pix;
        logic [0:0] row;
        logic [1:0] col;
        logic       fd, dd, drop;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(input logic st, iv, input logic [7:0] ip, input logic ordy,
                                input logic ird, ov, input logic [7:0] pix, input logic [0:0] row,
                                input logic [1:0] col, input logic fd, dd, drop);
        vec_t v;
        v.st = st; v.iv = iv; v.ip = ip; v.ordy = ordy; v.ird = ird; v.ov = ov;
        v.pix = pix; v.row = row; v.col = col; v.fd = fd; v.dd = dd; v.drop = drop;
        return v;
    endfunction

    function automatic logic [7:0] pix(input int pat, input int r, input int c);
        if (pat == 0) return 8'((r * 256 + c) & 255);
        return 8'((r * 13 + c * 3 + 90) & 255);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_frame(input int pat, input bit gaps, input int npix);
        int n = 0;
        int cyc = 0;
        int fd_early = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (n < npix && cyc < 40000) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_pixel = pix(pat, n / W, n % W);
            @(negedge clk);
            if (frame_done) fd_early++;
            if (in_valid && in_ready) n++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("fill_accepted", n, npix);
        check("frame_done_early", fd_early, 0);
        if (npix == NPIX) begin
            @(negedge clk);
            check("frame_done_pulse", {31'd0, frame_done}, 1);
            check("in_ready_in_drain", {31'd0, in_ready}, 0);
            tick();
        end
    endtask

    task automatic drain_frame(input int pat, input bit bp);
        int n = 0, cyc = 1, first = -1, bubbles = 0, hold = 0, fd_seen = 0, dd_early = 0;
        bit stalled = 1'b0;
        logic [31:0] saved = '0, cur;
        while (n < NPIX && cyc < 40000) begin
            if (bp) begin
                if (n == W - 1 && hold < 10) begin
                    out_ready = 1'b0;
                    hold++;
                end else begin
                    out_ready = ($urandom_range(0, 9) >= 3);
                end
            end else begin
                out_ready = 1'b1;
            end
            @(negedge clk);
            cur = {11'd0, out_pixel, out_row, out_col};
            if (frame_done) fd_seen++;
            if (drain_done) dd_early++;
            if (stalled) check("valid_held", {31'd0, out_valid}, 1);
            if (out_valid) begin
                if (first < 0) first = cyc;
                if (stalled) check("stall_stable", cur, saved);
                if (out_ready) begin
                    check("beat", cur, {11'd0, pix(pat, n / W, n % W), 5'(n / W), 8'(n % W)});
                    n++;
                end
            end else if (first >= 0) begin
                bubbles++;
            end
            stalled = out_valid && !out_ready;
            saved = cur;
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        check("drain_beats", n, NPIX);
        check("first_valid_latency", {31'd0, (first >= 0 && first <= 2)}, 1);
        if (!bp) check("no_bubbles", bubbles, 0);
        check("frame_done_once", fd_seen, 0);
        check("drain_done_early", dd_early, 0);
        @(negedge clk);
        check("drain_done_pulse", {30'd0, drain_done, out_valid}, 32'b10);
        tick();
        @(negedge clk);
        check("drain_done_single", {31'd0, drain_done}, 0);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected summary before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fd_cnt;

        tbl[0]  = mk(1, 0, 8'h00, 1,  0, 0, 8'h00, 0, 0,  0, 0, 0);
        tbl[1]  = mk(0, 1, 8'h10, 1,  1, 0, 8'h00, 0, 0,  0, 0, 0);
        tbl[2]  = mk(0, 1, 8'h11, 1,  1, 0, 8'h00, 0, 0,  0, 0, 0);
        tbl[3]  = mk(0, 1, 8'h12, 1,  1, 0, 8'h00, 0, 0,  0, 0, 0);
        tbl[4]  = mk(0, 0, 8'h00, 1,  1, 0, 8'h00, 0, 0,  0, 0, 0);
        tbl[5]  = mk(0, 1, 8'h13, 1,  1, 0, 8'h00, 0, 0,  0, 0, 0);
        tbl[6]  = mk(0, 1, 8'h14, 1,  1, 0, 8'h00, 0, 0,  0, 0, 0);
        tbl[7]  = mk(0, 1, 8'h15, 1,  1, 0, 8'h00, 0, 0,  0, 0, 0);
        tbl[8]  = mk(0, 1, 8'h16, 1,  1, 0, 8'h00, 0, 0,  0, 0, 0);
        tbl[9]  = mk(0, 1, 8'h17, 1,  1, 0, 8'h00, 0, 0,  0, 0, 0);
        tbl[10] = mk(0, 0, 8'h00, 1,  0, 0, 8'h00, 0, 0,  1, 0, 0);
        tbl[11] = mk(0, 0, 8'h00, 1,  0, 0, 8'h00, 0, 0,  0, 0, 0);
        tbl[12] = mk(0, 0, 8'h00, 1,  0, 1, 8'h10, 0, 0,  0, 0, 0);
        tbl[13] = mk(0, 0, 8'h00, 1,  0, 1, 8'h11, 0, 1,  0, 0, 0);
        tbl[14] = mk(1, 0, 8'h00, 1,  0, 1, 8'h12, 0, 2,  0, 0, 0);
        tbl[15] = mk(0, 0, 8'h00, 1,  0, 1, 8'h13, 0, 3,  0, 0, 0);
        tbl[16] = mk(0, 0, 8'h00, 0,  0, 1, 8'h14, 1, 0,  0, 0, 0);
        tbl[17] = mk(0, 0, 8'h00, 0,  0, 1, 8'h14, 1, 0,  0, 0, 0);
        tbl[18] = mk(0, 0, 8'h00, 1,  0, 1, 8'h14, 1, 0,  0, 0, 0);
        tbl[19] = mk(0, 0, 8'h00, 1,  0, 1, 8'h15, 1, 1,  0, 0, 0);
        tbl[20] = mk(0, 0, 8'h00, 1,  0, 1, 8'h16, 1, 2,  0, 0, 0);
        tbl[21] = mk(0, 0, 8'h00, 1,  0, 1, 8'h17, 1, 3,  0, 0, 0);
        tbl[22] = mk(0, 0, 8'h00, 1,  0, 0, 8'h00, 0, 0,  0, 1, 0);
        tbl[23] = mk(0, 1, 8'hFF, 1,  0, 0, 8'h00, 0, 0,  0, 0, 0);
        tbl[24] = mk(0, 0, 8'h00, 1,  0, 0, 8'h00, 0, 0,  0, 0, 1);

        // Reset state of both instances
        tick();
        tick();
        @(negedge clk);
        check("reset_ctl", {27'd0, in_ready, out_valid, frame_done, drain_done, drop_err}, 0);
        check("reset_data", {11'd0, out_pixel, out_row, out_col}, 0);
        check("reset_small", {16'd0, s_in_ready, s_out_valid, s_frame_done, s_drain_done,
                              s_drop_err, s_out_pixel, s_out_row, s_out_col}, 0);
        tick();
        rst_n = 1'b1;

        // Small geometry, cycle-accurate table: gap, start during drain, stall, drop in IDLE
        for (int i = 0; i < 25; i++) begin
            s_start     = tbl[i].st;
            s_in_valid  = tbl[i].iv;
            s_in_pixel  = tbl[i].ip;
            s_out_ready = tbl[i].ordy;
            @(negedge clk);
            check($sformatf("small_ctl[%0d]", i),
                  {27'd0, s_in_ready, s_out_valid, s_frame_done, s_drain_done, s_drop_err},
                  {27'd0, tbl[i].ird, tbl[i].ov, tbl[i].fd, tbl[i].dd, tbl[i].drop});
            if (tbl[i].ov)
                check($sformatf("small_beat[%0d]", i), {21'd0, s_out_pixel, s_out_row, s_out_col},
                      {21'd0, tbl[i].pix, tbl[i].row, tbl[i].col});
            tick();
        end
        s_in_valid = 1'b0;

        // Full frame, no stalls
        fill_frame(0, 1'b0, NPIX);
        drain_frame(0, 1'b0);

        // Pixel offered in IDLE is dropped and flagged
        in_valid = 1'b1;
        in_pixel = 8'hEE;
        @(negedge clk);
        check("idle_in_ready", {31'd0, in_ready}, 0);
        check("drop_err_before", {31'd0, drop_err}, 0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("drop_err_set", {31'd0, drop_err}, 1);
        tick();

        // Input gaps, then drain under backpressure
        fill_frame(0, 1'b1, NPIX);
        drain_frame(0, 1'b1);
        check("drop_err_sticky", {31'd0, drop_err}, 1);

        // Reset after 1000 accepted pixels, then refill from (0,0)
        fill_frame(1, 1'b0, 1000);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_ctl", {27'd0, in_ready, out_valid, frame_done, drain_done, drop_err}, 0);
        check("midreset_data", {11'd0, out_pixel, out_row, out_col}, 0);
        fd_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            if (frame_done || in_ready) fd_cnt++;
        end
        check("midreset_stays_idle", fd_cnt, 0);
        tick();
        fill_frame(1, 1'b0, NPIX);
        drain_frame(1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
